// File: rtl/node_frame_serializer.sv
// node_frame_serializer
//   Takes a coherent one-cycle snapshot of every node position from one
//   simulation core on snap_req, then streams it out one node per beat over a
//   valid/ready interface. The core may keep updating positions while a frame
//   is streamed; the consumer always sees the frame captured at the request.
//
//   Ports:
//     clk, reset          clock; synchronous active-low reset
//     nodes_x, nodes_y    flattened positions, node i at [(i+1)*COORD_W-1 : i*COORD_W]
//     snap_req            single-cycle snapshot request
//     out_valid/out_ready beat handshake
//     out_x, out_y        snapshot coordinates of node out_index
//     out_index           node index of the beat
//     out_first/out_last  index 0 / index NODE_COUNT-1, qualified by out_valid
//     out_core_id         constant CORE_ID
//     busy                frame in flight
//     frame_count         completed frames, wraps at 16 bits
//     drop_count          ignored snap_req pulses, saturates at 0xFF
//
//   Optional feature: define NODE_SERIALIZER_PENDING_EN to hold one request
//   that arrives mid-frame and start the next frame back-to-back on the last
//   beat. Without it every request during a frame is dropped and counted.
module node_frame_serializer #(
  parameter int NODE_COUNT = 5,
  parameter int CORE_ID    = 1,
  parameter int COORD_W    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NODE_COUNT*COORD_W-1:0] nodes_x,
  input  logic [NODE_COUNT*COORD_W-1:0] nodes_y,
  input  logic                          snap_req,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COORD_W-1:0]            out_x,
  output logic [COORD_W-1:0]            out_y,
  output logic [7:0]                    out_index,
  output logic                          out_first,
  output logic                          out_last,
  output logic [7:0]                    out_core_id,
  output logic                          busy,
  output logic [15:0]                   frame_count,
  output logic [7:0]                    drop_count
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;
  localparam logic [7:0] LAST_IDX = 8'(NODE_COUNT - 1);
  localparam int         IW       = $clog2(NODE_COUNT);

  // Snapshot bank; packed layout matches the flattened input buses directly.
  logic [NODE_COUNT-1:0][COORD_W-1:0] bank_x_q, bank_y_q;

  logic [0:0]  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] frame_q, frame_d;
  logic [7:0]  drop_q, drop_d;
  logic        snap_we;
  logic        drop_inc;
  logic        xfer, at_last;
  logic [IW-1:0] sel;

`ifdef NODE_SERIALIZER_PENDING_EN
  logic pend_q, pend_d;
`endif

  assign xfer    = (state_q == S_STREAM) && out_ready;
  assign at_last = (idx_q == LAST_IDX);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    snap_we  = 1'b0;
    drop_inc = 1'b0;
`ifdef NODE_SERIALIZER_PENDING_EN
    pend_d   = pend_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (snap_req) begin
          snap_we = 1'b1;
          idx_d   = 8'd0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
`ifdef NODE_SERIALIZER_PENDING_EN
        // One request is held; a second while one is held is dropped.
        if (snap_req) begin
          if (pend_q) drop_inc = 1'b1;
          else        pend_d   = 1'b1;
        end
`else
        if (snap_req) drop_inc = 1'b1;
`endif
        if (xfer) begin
          if (at_last) begin
            frame_d = frame_q + 16'd1;
            idx_d   = 8'd0;
`ifdef NODE_SERIALIZER_PENDING_EN
            // Restart in the same edge so the next frame follows with no gap.
            if (pend_q || snap_req) begin
              snap_we = 1'b1;
              pend_d  = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    drop_d = (drop_inc && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= 8'd0;
      frame_q  <= 16'd0;
      drop_q   <= 8'd0;
      bank_x_q <= '0;
      bank_y_q <= '0;
`ifdef NODE_SERIALIZER_PENDING_EN
      pend_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
`ifdef NODE_SERIALIZER_PENDING_EN
      pend_q  <= pend_d;
`endif
      if (snap_we) begin
        bank_x_q <= nodes_x;
        bank_y_q <= nodes_y;
      end
    end
  end

  // Outputs come only from registered bank and index, never from nodes_*.
  assign sel         = idx_q[IW-1:0];
  assign out_x       = bank_x_q[sel];
  assign out_y       = bank_y_q[sel];
  assign out_valid   = (state_q == S_STREAM);
  assign busy        = (state_q == S_STREAM);
  assign out_index   = idx_q;
  assign out_first   = out_valid && (idx_q == 8'd0);
  assign out_last    = out_valid && at_last;
  assign out_core_id = 8'(CORE_ID);
  assign frame_count = frame_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_node_frame_serializer.sv
module tb_node_frame_serializer;
  localparam int N   = 5;
  localparam int W   = 32;
  localparam int CID = 1;
  localparam int VW  = 108;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N*W-1:0]   nodes_x, nodes_y;
  logic             snap_req = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid, out_first, out_last, busy;
  logic [W-1:0]     out_x, out_y;
  logic [7:0]       out_index, out_core_id, drop_count;
  logic [15:0]      frame_count;
  logic [W-1:0]     nx [N];
  logic [W-1:0]     ny [N];

  int vectors = 0;
  int miscompares = 0;

  node_frame_serializer #(.NODE_COUNT(N), .CORE_ID(CID), .COORD_W(W)) dut (
    .clk(clk), .reset(reset), .nodes_x(nodes_x), .nodes_y(nodes_y),
    .snap_req(snap_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_index(out_index),
    .out_first(out_first), .out_last(out_last), .out_core_id(out_core_id),
    .busy(busy), .frame_count(frame_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    nodes_x = '0;
    nodes_y = '0;
    for (int i = 0; i < N; i++) begin
      nodes_x[i*W +: W] = nx[i];
      nodes_y[i*W +: W] = ny[i];
    end
  end

  // Reference model: a frame is a queue of beats still owed to the consumer.
  typedef struct { logic [W-1:0] x; logic [W-1:0] y; int idx; } beat_t;
  beat_t mq[$];
  int    m_frames = 0;
  int    m_drops  = 0;
  bit    m_pend   = 0;

  task automatic push_frame();
    for (int i = 0; i < N; i++) mq.push_back('{x: nx[i], y: ny[i], idx: i});
  endtask

  task automatic model_edge(input bit snap, input bit rdy);
    bit lastx, pend_old;
    if (!reset) begin
      mq.delete(); m_frames = 0; m_drops = 0; m_pend = 0;
      return;
    end
    if (mq.size() == 0) begin
      if (snap) push_frame();
      return;
    end
    lastx    = rdy && (mq[0].idx == N - 1);
    pend_old = m_pend;
`ifdef NODE_SERIALIZER_PENDING_EN
    if (snap) begin
      if (m_pend) m_drops = (m_drops == 255) ? 255 : m_drops + 1;
      else        m_pend = 1;
    end
`else
    if (snap) m_drops = (m_drops == 255) ? 255 : m_drops + 1;
`endif
    if (rdy) void'(mq.pop_front());
    if (lastx) begin
      m_frames = (m_frames + 1) % 65536;
`ifdef NODE_SERIALIZER_PENDING_EN
      if (pend_old || snap) begin
        push_frame();
        m_pend = 0;
      end
`else
      if (pend_old) m_pend = 0;
`endif
    end
  endtask

  task automatic tick(input bit snap, input bit rdy);
    snap_req  = snap;
    out_ready = rdy;
    model_edge(snap, rdy);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    if (mq.size() > 0)
      return {2'b11, mq[0].idx == 0, mq[0].idx == N - 1, 8'(mq[0].idx),
              mq[0].x, mq[0].y, 16'(m_frames), 8'(m_drops), 8'(CID)};
    return {4'b0, 8'h0, 64'h0, 16'(m_frames), 8'(m_drops), 8'(CID)};
  endfunction

  // Index and data are don't-care while idle.
  function automatic logic [VW-1:0] obs_vec();
    logic [VW-1:0] v;
    v = {busy, out_valid, out_first, out_last, out_index, out_x, out_y,
         frame_count, drop_count, out_core_id};
    if (mq.size() == 0) v[103:32] = '0;
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    tick(1, 1);
    tick(0, 0);
    vectors++;
    if ({busy, out_valid, out_first, out_last} !== 4'b0) begin
      miscompares++; $display("FAIL reset_flags got %b want 0000", {busy, out_valid, out_first, out_last});
    end
    vectors++;
    if ({out_index, out_x, out_y} !== 72'h0) begin
      miscompares++; $display("FAIL reset_data got %h want 0", {out_index, out_x, out_y});
    end
    vectors++;
    if ({frame_count, drop_count} !== 24'h0) begin
      miscompares++; $display("FAIL reset_counts got %h want 0", {frame_count, drop_count});
    end
    vectors++;
    if (out_core_id !== 8'(CID)) begin
      miscompares++; $display("FAIL core_id got %h want %h", out_core_id, 8'(CID));
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < N; i++) begin nx[i] = 32'(16 * i + 1); ny[i] = 32'(32 * i + 2); end
    tick(1, 1);
    for (int c = 1; c <= 6; c++) begin
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL basic c%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c <= 5) begin
        vectors++;
        if ({out_valid, out_x, out_y} !== {1'b1, 32'(16 * (c - 1) + 1), 32'(32 * (c - 1) + 2)}) begin
          miscompares++; $display("FAIL basic_beat c%0d got %h/%h want %h/%h", c, out_x, out_y,
                                  32'(16 * (c - 1) + 1), 32'(32 * (c - 1) + 2));
        end
      end
      if (c < 6) tick(0, 1);
    end
    vectors++;
    if ({out_valid, frame_count} !== {1'b0, 16'd1}) begin
      miscompares++; $display("FAIL basic_end got v=%b fc=%0d want v=0 fc=1", out_valid, frame_count);
    end
  endtask

  task automatic test_backpressure();
    int c;
    for (int i = 0; i < N; i++) begin nx[i] = $urandom; ny[i] = $urandom; end
    tick(1, 0);
    c = 0;
    while (mq.size() > 0 && c < 120) begin
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL backpressure c%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      for (int i = 0; i < N; i++) begin nx[i] = $urandom; ny[i] = $urandom; end
      tick((c < 20) && ($urandom_range(0, 7) == 0), (c % 3) == 2);
      c++;
    end
    vectors++;
    if (mq.size() != 0) begin
      miscompares++; $display("FAIL backpressure_timeout got %0d beats left want 0", mq.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) begin nx[i] = $urandom; ny[i] = $urandom; end
    tick(1, 1);
    tick(0, 1);
    tick(0, 1);
    reset = 1'b0;
    tick(0, 1);
    reset = 1'b1;
    vectors++;
    if ({out_valid, busy, out_index, frame_count, drop_count} !== 34'h0) begin
      miscompares++; $display("FAIL reset_mid got v=%b b=%b i=%0d fc=%0d dc=%0d want all 0",
                              out_valid, busy, out_index, frame_count, drop_count);
    end
    tick(1, 1);
    for (int c = 1; c <= 6; c++) begin
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL reset_mid_frame c%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      tick(0, 1);
    end
  endtask

`ifdef NODE_SERIALIZER_PENDING_EN
  task automatic test_pending();
    reset = 1'b0; tick(0, 0); reset = 1'b1;
    for (int i = 0; i < N; i++) begin nx[i] = $urandom; ny[i] = $urandom; end
    for (int c = 0; c <= 11; c++) begin
      if (c >= 1) begin
        vectors++;
        if (obs_vec() !== exp_vec()) begin
          miscompares++; $display("FAIL pending c%0d got %h want %h", c, obs_vec(), exp_vec());
        end
        vectors++;
        if (out_valid !== (c <= 10)) begin
          miscompares++; $display("FAIL pending_gap c%0d got %b want %b", c, out_valid, c <= 10);
        end
      end
      tick(c == 0 || c == 2, 1);
    end
    vectors++;
    if ({frame_count, drop_count} !== {16'd2, 8'd0}) begin
      miscompares++; $display("FAIL pending_counts got fc=%0d dc=%0d want 2/0", frame_count, drop_count);
    end
  endtask
`else
  task automatic test_drop();
    reset = 1'b0; tick(0, 0); reset = 1'b1;
    for (int i = 0; i < N; i++) begin nx[i] = $urandom; ny[i] = $urandom; end
    for (int c = 0; c <= 7; c++) begin
      if (c >= 1) begin
        vectors++;
        if (obs_vec() !== exp_vec()) begin
          miscompares++; $display("FAIL drop c%0d got %h want %h", c, obs_vec(), exp_vec());
        end
      end
      tick(c == 0 || c == 2 || c == 5, 1);
    end
    vectors++;
    if ({frame_count, drop_count} !== {16'd1, 8'd2}) begin
      miscompares++; $display("FAIL drop_counts got fc=%0d dc=%0d want 1/2", frame_count, drop_count);
    end
    tick(1, 0);
    for (int k = 0; k < 300; k++) begin
      if (k % 50 == 0) begin
        vectors++;
        if (obs_vec() !== exp_vec()) begin
          miscompares++; $display("FAIL drop_sat k%0d got %h want %h", k, obs_vec(), exp_vec());
        end
      end
      tick(1, 0);
    end
    vectors++;
    if (drop_count !== 8'hFF) begin
      miscompares++; $display("FAIL drop_saturate got %h want ff", drop_count);
    end
    for (int c = 0; c < 7; c++) tick(0, 1);
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL drop_drain got %h want %h", obs_vec(), exp_vec());
    end
  endtask
`endif

  task automatic test_reset_precedence();
    reset = 1'b0;
    tick(1, 1);
    reset = 1'b1;
    vectors++;
    if ({out_valid, busy} !== 2'b00) begin
      miscompares++; $display("FAIL reset_prec got v=%b b=%b want 0/0", out_valid, busy);
    end
    tick(0, 1);
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL reset_prec_idle got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin nx[i] = '0; ny[i] = '0; end
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
`ifdef NODE_SERIALIZER_PENDING_EN
    test_pending();
`else
    test_drop();
`endif
    test_reset_precedence();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
